serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder controller. It accepts two WIDTH-bit operands through a valid handshake and sequences a single 1-bit add slice (sum/carry) across all bit positions, LSB first, one bit per clock. It returns a WIDTH+1-bit result (carry-out as MSB) with a one-cycle out_valid pulse. It is a minimum-area alternative to a parallel adder in lab datapaths.

---
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder slice stepped LSB first.
// Defining SERIAL_ADD_OVF_EN adds the out_ovf signed-overflow output.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH:0]   out_sum
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_sum_q, out_sum_d;
  logic             ovf_q, ovf_d;

  logic bit_s;
  logic bit_c;

  // The operand registers shift right, so the active bit is always at index 0.
  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    out_sum_d   = '0;
    ovf_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        sum_d[cnt_q] = bit_s;
        carry_d      = bit_c;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB; bit_c is the carry out of it.
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = {bit_c, sum_d};
          ovf_d       = carry_q ^ bit_c;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=2 instances, vector table,
// multi-cycle corner sequences and randomized operands against a sum model.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       v8, v2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, busy2, ov8, ov2;
  logic [8:0] sum8;
  logic [2:0] sum2;
  logic       ovf8, ovf2;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_a(a8), .in_b(b8),
    .busy(busy8), .out_valid(ov8), .out_sum(sum8)
`ifdef SERIAL_ADD_OVF_EN
    , .out_ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_a(a2), .in_b(b2),
    .busy(busy2), .out_valid(ov2), .out_sum(sum2)
`ifdef SERIAL_ADD_OVF_EN
    , .out_ovf(ovf2)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer addition and sign-based overflow rule.
  function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    logic [8:0]  sm;
    logic        ovf;
    s   = int'(a) + int'(b);
    sm  = s[8:0];
    ovf = (a[w-1] == b[w-1]) && (sm[w-1] != a[w-1]);
    return {ovf, sm};
  endfunction

  function automatic logic [8:0] cur_sum(input bit sel);
    return sel ? {6'd0, sum2} : sum8;
  endfunction

  // One operation from IDLE; watches W+3 cycles after the accepting edge.
  task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp_sum, input logic exp_ovf, input string name);
    int w;
    int pulses;
    int pulse_k;
    logic [8:0] got_sum;
    logic got_ovf;
    bit nonzero_idle;
    w = sel ? 2 : 8;
    pulses = 0;
    pulse_k = -1;
    got_sum = '0;
    got_ovf = 1'b0;
    nonzero_idle = 1'b0;
    if (sel) begin a2 = a[1:0]; b2 = b[1:0]; v2 = 1'b1; end
    else begin a8 = a; b8 = b; v8 = 1'b1; end
    @(posedge clk); #1;
    v8 = 1'b0;
    v2 = 1'b0;
    chk({name, "_busy"}, sel ? busy2 : busy8, 1'b1);
    for (int k = 0; k <= w + 2; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (sel ? ov2 : ov8) begin
        pulses++;
        pulse_k = k;
        got_sum = cur_sum(sel);
        got_ovf = sel ? ovf2 : ovf8;
      end else if (cur_sum(sel) != 9'd0) begin
        nonzero_idle = 1'b1;
      end
    end
    chk({name, "_pulses"}, pulses, 1);
    chk({name, "_latency"}, pulse_k, w);
    chk({name, "_sum"}, got_sum, exp_sum);
    chk({name, "_sum_zero"}, nonzero_idle, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk({name, "_ovf"}, got_ovf, exp_ovf);
`else
    if (got_ovf !== 1'b0 && exp_ovf === 1'bx) chk({name, "_ovf"}, got_ovf, 1'b0);
`endif
  endtask

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] m;
    int pulses;
    int pk[2];
    logic [8:0] ps[2];
    bit seen;

    vecs[0] = '{8'h0F, 8'h01, 9'h010, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 9'h1FE, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 9'h000, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 9'h046, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 9'h0FF, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 9'h003, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 9'h080, 1'b1};
    vecs[7] = '{8'hFF, 8'h01, 9'h100, 1'b0};
    vecs[8] = '{8'h80, 8'hFF, 9'h17F, 1'b1};

    rst_n = 1'b0;
    v8 = 1'b0; v2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    #1;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_ov8", ov8, 1'b0);
    chk("rst_sum8", sum8, 9'd0);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_ovf8", ovf8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    run_op(1'b1, 8'h03, 8'h03, 9'h006, 1'b0, "w2_full");

    // in_valid held through RUN/DONE with different operands.
    pulses = 0;
    pk[0] = -1; pk[1] = -1; ps[0] = '0; ps[1] = '0;
    a8 = 8'h12; b8 = 8'h34; v8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55;
    for (int k = 0; k <= 2 * 8 + 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (ov8) begin
        if (pulses < 2) begin pk[pulses] = k; ps[pulses] = sum8; end
        pulses++;
      end
      if (k == 8 + 2) v8 = 1'b0;
    end
    chk("hold_pulses", pulses, 2);
    chk("hold_k0", pk[0], 8);
    chk("hold_sum0", ps[0], 9'h046);
    chk("hold_k1", pk[1], 2 * 8 + 2);
    chk("hold_sum1", ps[1], 9'h0FF);

    // Reset during the 4th RUN cycle discards the operation.
    a8 = 8'h80; b8 = 8'h80; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_ov", ov8, 1'b0);
    chk("abort_sum", sum8, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov8 || busy8) seen = 1'b1;
    end
    chk("abort_no_result", seen, 1'b0);
    run_op(1'b0, 8'h01, 8'h02, 9'h003, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      m = model(8, ra, rb);
      run_op(1'b0, ra, rb, m[8:0], m[9], $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(3, 0));
      rb = 8'($urandom_range(3, 0));
      m = model(2, ra, rb);
      run_op(1'b1, ra, rb, m[8:0], m[9], $sformatf("rnd2_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
